stopwatch_core: RTL and testbench

Parametrised timekeeping core for the stopwatch display path. Holds an N-digit BCD count with per-digit modulus, prescaled run/pause, count-up or count-down with terminal detection, digit adjust mode and lap capture. Sits between the debounced button/switch logic and the seven-segment driver, which consumes count_bcd or lap_bcd.

---
 rtl/stopwatch_core.sv | 164 ++++++++++++++++
 tb/tb_stopwatch_core.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_core.sv
// rtl/stopwatch_core.sv - N-digit BCD stopwatch core with per-digit modulus, prescaled run/pause, up/down, adjust and lap
module stopwatch_core #(
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] RADIX_MASK = NUM_DIGITS'(4'b1010),
  parameter int                    TICK_DIV   = 1000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    toggle,
  input  logic                    down,
  input  logic                    adj,
  input  logic [2:0]              adj_sel,
  input  logic [3:0]              adj_val,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] count_bcd,
  output logic [4*NUM_DIGITS-1:0] lap_bcd,
  output logic                    lap_valid,
  output logic                    running,
  output logic                    done,
  output logic                    wrap
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_ADJUST, ST_DONE} state_t;

  state_t        state, state_n;
  logic [W-1:0]  count_q, count_n, lap_q, lap_n, inc_v, dec_v;
  logic [PW-1:0] presc_q, presc_n;
  logic          lap_valid_q, lap_valid_n;
  logic          wrap_q, wrap_n, running_q, done_q, all_max, tick;

  function automatic logic [3:0] digit_max(input int i);
    return RADIX_MASK[i] ? 4'd5 : 4'd9;
  endfunction

  // Ripple carry/borrow across digits; carry out of the top digit means all digits were at max.
  always_comb begin : ripple
    logic       carry;
    logic       borrow;
    logic [3:0] d;
    inc_v  = count_q;
    dec_v  = count_q;
    carry  = 1'b1;
    borrow = 1'b1;
    d      = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (d >= digit_max(i)) begin
          inc_v[4*i +: 4] = 4'd0;
        end else begin
          inc_v[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          dec_v[4*i +: 4] = digit_max(i);
        end else begin
          dec_v[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    all_max = carry;
  end

  assign tick = (presc_q == PMAX);

  always_comb begin
    state_n     = state;
    count_n     = count_q;
    presc_n     = presc_q;
    lap_n       = lap_q;
    lap_valid_n = lap_valid_q;
    wrap_n      = 1'b0;
    if (clear) begin
      count_n     = '0;
      presc_n     = '0;
      lap_n       = '0;
      lap_valid_n = 1'b0;
      state_n     = adj ? ST_ADJUST : ST_STOP;
    end else begin
      if (lap) begin
        lap_n       = count_q;
        lap_valid_n = 1'b1;
      end
      if (adj) begin
        state_n = ST_ADJUST;
        presc_n = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (adj_sel == 3'(i)) begin
            count_n[4*i +: 4] = (adj_val > digit_max(i)) ? digit_max(i) : adj_val;
          end
        end
      end else begin
        case (state)
          ST_ADJUST: state_n = ST_STOP;
          ST_STOP: begin
            if (toggle) state_n = ST_RUN;
          end
          ST_RUN: begin
            // Pausing keeps the prescaler so a resume finishes the interrupted period.
            if (toggle) begin
              state_n = ST_STOP;
            end else if (tick) begin
              presc_n = '0;
              if (!down) begin
                count_n = inc_v;
                wrap_n  = all_max;
              end else if (count_q == '0) begin
                state_n = ST_DONE;
              end else begin
                count_n = dec_v;
                if (dec_v == '0) state_n = ST_DONE;
              end
            end else begin
              presc_n = presc_q + PW'(1);
            end
          end
          ST_DONE: begin
            presc_n = '0;
            if (toggle) state_n = ST_STOP;
          end
          default: state_n = ST_STOP;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_STOP;
      count_q     <= '0;
      presc_q     <= '0;
      lap_q       <= '0;
      lap_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state       <= state_n;
      count_q     <= count_n;
      presc_q     <= presc_n;
      lap_q       <= lap_n;
      lap_valid_q <= lap_valid_n;
      wrap_q      <= wrap_n;
      running_q   <= (state_n == ST_RUN);
      done_q      <= (state_n == ST_DONE);
    end
  end

  assign count_bcd = count_q;
  assign lap_bcd   = lap_q;
  assign lap_valid = lap_valid_q;
  assign running   = running_q;
  assign done      = done_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb/tb_stopwatch_core.sv - scoreboard bench for stopwatch_core (4 digits MM:SS, TICK_DIV=4)
module tb_stopwatch_core;

  localparam int ND = 4;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0, toggle = 1'b0, down = 1'b0, adj = 1'b0, lap = 1'b0;
  logic [2:0]  adj_sel = 3'd0;
  logic [3:0]  adj_val = 4'd0;
  logic [15:0] count_bcd, lap_bcd;
  logic        lap_valid, running, done, wrap;

  int          total = 0;
  int          bad = 0;
  logic [15:0] sb[$];
  logic [15:0] prev_count;
  logic [15:0] sb_exp;
  logic        mon_en = 1'b0;

  stopwatch_core #(.NUM_DIGITS(ND), .RADIX_MASK(4'b1010), .TICK_DIV(TD)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .toggle(toggle), .down(down),
    .adj(adj), .adj_sel(adj_sel), .adj_val(adj_val), .lap(lap),
    .count_bcd(count_bcd), .lap_bcd(lap_bcd), .lap_valid(lap_valid),
    .running(running), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] bcd2(input int v);
    return 16'(((v / 10) << 4) | (v % 10));
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_toggle();
    toggle = 1'b1; cyc(); toggle = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1; cyc(); clear = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1; cyc(); lap = 1'b0;
  endtask

  task automatic set_digit(input int sel, input int val);
    adj = 1'b1; adj_sel = 3'(sel); adj_val = 4'(val); cyc();
  endtask

  task automatic end_adj();
    adj = 1'b0; cyc();
  endtask

  task automatic wait_sb(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    check(tag, sb.size(), 0);
    sb.delete();
  endtask

  // Every change of count_bcd while monitoring must match the next queued value.
  initial begin
    prev_count = 16'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && count_bcd !== prev_count) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", count_bcd, prev_count);
        end else begin
          sb_exp = sb.pop_front();
          check("sb_count", count_bcd, sb_exp);
        end
      end
      prev_count = count_bcd;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench stalled");
  end

  initial begin
    cyc(); cyc();
    check("rst_count", count_bcd, 16'h0);
    check("rst_lap", lap_bcd, 16'h0);
    check("rst_lap_valid", lap_valid, 0);
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_wrap", wrap, 0);
    rst_n = 1'b1;
    cyc();

    // Reset mid-run from 0x0137
    set_digit(0, 7); set_digit(1, 3); set_digit(2, 1); end_adj();
    check("adj_0137", count_bcd, 16'h0137);
    pulse_toggle();
    check("run_0137", running, 1);
    cyc(); cyc();
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", count_bcd, 16'h0);
    check("arst_running", running, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) cyc();
    check("post_rst_running", running, 0);
    check("post_rst_count", count_bcd, 16'h0);

    // Up count
    pulse_clear();
    mon_en = 1'b1;
    sb.push_back(16'h0001); sb.push_back(16'h0002);
    pulse_toggle();
    wait_sb("sb_up_first", 20);
    pulse_toggle();
    check("up_stop_running", running, 0);
    mon_en = 1'b0;
    set_digit(0, 9); set_digit(1, 5); end_adj();
    mon_en = 1'b1;
    sb.push_back(16'h0100);
    pulse_toggle();
    wait_sb("sb_up_minute", 10);
    check("up_0100", count_bcd, 16'h0100);
    pulse_toggle();
    mon_en = 1'b0;
    set_digit(0, 9); set_digit(1, 5); set_digit(2, 9); set_digit(3, 5); end_adj();
    check("adj_5959", count_bcd, 16'h5959);
    mon_en = 1'b1;
    sb.push_back(16'h0000);
    pulse_toggle();
    wait_sb("sb_up_wrap", 10);
    check("wrap_high", wrap, 1);
    cyc();
    check("wrap_low", wrap, 0);
    check("wrap_still_running", running, 1);
    pulse_toggle();

    // Down count from 0x0100 to DONE
    mon_en = 1'b0;
    set_digit(0, 0); set_digit(1, 0); set_digit(2, 1); set_digit(3, 0); end_adj();
    down = 1'b1;
    mon_en = 1'b1;
    for (int v = 59; v >= 0; v--) sb.push_back(bcd2(v));
    pulse_toggle();
    wait_sb("sb_down", 300);
    check("down_done", done, 1);
    check("down_running", running, 0);
    repeat (5) cyc();
    check("done_frozen", count_bcd, 16'h0);
    pulse_toggle();
    check("done_exit", done, 0);
    check("done_exit_running", running, 0);
    // Down from zero: no change, DONE on first tick
    pulse_toggle();
    repeat (3) cyc();
    check("zero_down_not_yet", done, 0);
    cyc();
    check("zero_down_done", done, 1);
    check("zero_down_count", count_bcd, 16'h0);
    pulse_toggle();
    down = 1'b0;

    // Pause/resume
    pulse_clear();
    sb.push_back(16'h0001);
    pulse_toggle();
    repeat (6) cyc();
    pulse_toggle();
    repeat (20) cyc();
    check("pause_count", count_bcd, 16'h0001);
    check("pause_running", running, 0);
    sb.push_back(16'h0002);
    pulse_toggle();
    cyc();
    check("resume_1cyc", count_bcd, 16'h0001);
    cyc();
    check("resume_2cyc", count_bcd, 16'h0002);
    repeat (3) cyc();
    pulse_toggle();
    check("tick_toggle_running", running, 0);
    repeat (8) cyc();
    check("tick_toggle_nostep", count_bcd, 16'h0002);
    check("sb_pause_empty", sb.size(), 0);

    // Adjust
    mon_en = 1'b0;
    set_digit(1, 9);
    check("adj_clamp", count_bcd, 16'h0052);
    set_digit(5, 3);
    check("adj_oob", count_bcd, 16'h0052);
    toggle = 1'b1; cyc(); toggle = 1'b0;
    check("adj_toggle_ignored", running, 0);
    set_digit(0, 9); set_digit(3, 7);
    check("adj_more", count_bcd, 16'h5059);
    end_adj();
    repeat (8) cyc();
    check("adj_exit_stop", running, 0);
    check("adj_exit_count", count_bcd, 16'h5059);

    // Lap and priority
    pulse_clear();
    set_digit(0, 3); set_digit(1, 2); end_adj();
    mon_en = 1'b1;
    sb.push_back(16'h0024);
    pulse_toggle();
    pulse_lap();
    check("lap_value", lap_bcd, 16'h0023);
    check("lap_valid", lap_valid, 1);
    check("lap_running", running, 1);
    wait_sb("sb_lap", 10);
    check("lap_held", lap_bcd, 16'h0023);
    mon_en = 1'b0;
    clear = 1'b1; lap = 1'b1; toggle = 1'b1;
    cyc();
    clear = 1'b0; lap = 1'b0; toggle = 1'b0;
    check("prio_count", count_bcd, 16'h0);
    check("prio_lap", lap_bcd, 16'h0);
    check("prio_lap_valid", lap_valid, 0);
    check("prio_running", running, 0);
    repeat (6) cyc();
    check("prio_stopped", count_bcd, 16'h0);

    check("sb_final", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
